lif_neuron_param: RTL and testbench
===================================

Name: lif_neuron_param

Overview:
- Parametrised, multi-input leaky-integrate-and-fire neuron; next generation of the fixed 8-bit, single-input, fixed-threshold accumulator/FSM neuron top.
- Adds a weighted synaptic sum over NUM_IN inputs, a runtime threshold and reset potential, periodic leak, a refractory period, saturating arithmetic and a spike counter.
- Sits directly under the board top-level; `spike` drives the LED.
- `state_dbg` and `membrane` are exposed for debug.

Parameters:
- WIDTH, 8: membrane, weight, threshold, leak and v_reset width.
- NUM_IN, 4: number of synaptic inputs (≥1).
- LEAK_DIV, 4: leak applied once every LEAK_DIV enabled INTEG cycles (≥1).
- REFRAC_W, 4: width of the refractory-length input.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  enables integration and the leak prescaler.
- spike_in  in  NUM_IN  synaptic input i active-high, sampled each clk.
- weight  in  NUM_IN*WIDTH  unsigned weight of input i at [i*WIDTH +: WIDTH].
- threshold  in  WIDTH  fire when the next membrane value ≥ threshold.
- leak  in  WIDTH  amount subtracted per leak tick.
- v_reset  in  WIDTH  membrane value loaded on fire.
- refrac_cycles  in  REFRAC_W  refractory length in cycles (0 = none).
- membrane  out  WIDTH  membrane potential register.
- spike  out  1  one-cycle fire pulse (state==FIRE).
- state_dbg  out  2  encoded state.
- spike_count  out  16  saturating count of fires.

Behaviour:
- Reset (async, immediate):
  - Outputs: membrane=0, state=INTEG, spike=0, spike_count=0.
  - Internal: prescaler=0, refractory counter=0.
  - Reset mid-FIRE/REFRAC aborts the operation with no residual pulse.
- States (state_dbg encoding): INTEG=2'd0, FIRE=2'd1, REFRAC=2'd2, 2'd3 illegal → INTEG.
- INTEG with en=1, each edge:
  - syn = Σ weight[i] for spike_in[i]=1. Width WIDTH+clog2(NUM_IN)+1, no overflow.
  - nxt = membrane + syn − (tick ? leak : 0), computed signed at WIDTH+clog2(NUM_IN)+2 bits.
  - Clamp nxt to [0, 2^WIDTH−1].
  - If clamped nxt ≥ threshold: membrane←v_reset, state←FIRE, spike_count+1 (holds at 16'hFFFF).
  - Else membrane←clamped nxt.
- INTEG with en=0: membrane and prescaler hold.
- Leak tick:
  - Prescaler counts 0..LEAK_DIV−1 only in INTEG with en=1; tick when prescaler==LEAK_DIV−1, then wraps to 0.
  - Prescaler holds in FIRE/REFRAC.
  - Simultaneous synaptic input and tick: both applied in the same nxt.
- FIRE (exactly one cycle, independent of en):
  - spike=1, membrane=v_reset, inputs ignored.
  - Next state REFRAC, with counter←refrac_cycles; if refrac_cycles==0, next state INTEG.
- REFRAC (independent of en):
  - Inputs ignored, membrane held at v_reset.
  - Counter decrements each cycle; at counter==1 next state INTEG.
  - Total refractory cycles = refrac_cycles.
  - refrac_cycles is sampled only on FIRE entry.
- Latency: input sampled at edge t crossing threshold → spike high for the cycle following edge t; membrane reads v_reset in that cycle.
- Boundaries:
  - threshold=0: fires on every enabled INTEG cycle.
  - v_reset ≥ threshold: does not re-fire until the next INTEG evaluation.
  - Clamp applies before the threshold compare.
- All outputs registered except spike and state_dbg, which decode the state register.

Decomposition:
- Package lif_pkg:
  - state enum/localparams INTEG/FIRE/REFRAC;
  - SPIKE_CNT_W=16;
  - a function returning the syn width from WIDTH and NUM_IN.
- Sub-module lif_syn_sum: combinational masked weight sum, parametrised by WIDTH and NUM_IN.
- Prescaler, FSM and counters stay in lif_neuron_param.

Test Plan:
Common setup: WIDTH=8, NUM_IN=4, LEAK_DIV=4, weights w0..w3={20,10,5,1}, threshold=50, leak=0, v_reset=0, refrac=3, en=1.
- Reset: assert rst_n=0 mid-simulation → membrane=0, spike=0, state_dbg=0, spike_count=0 asynchronously (before the next edge).
- Integrate/fire/refractory: spike_in=4'b0001 held → membrane 20, 40, then fire.
  - spike=1 for one cycle, membrane=0, spike_count=1.
  - 3 REFRAC cycles with membrane=0 despite input.
  - Then membrane 20, 40, fire again.
- Leak floor:
  - Preload membrane=3 (spike_in=4'b1000 ×3).
  - Then inputs idle, leak=2 → membrane 1 on the next tick, then 0 on the following tick (clamped, no wrap).
  - Ticks spaced 4 cycles apart.
- Saturation: threshold=255, spike_in=4'b1111 (36/cycle) → membrane 36..252, next edge clamps to 255 and fires, spike_count increments.
- Zero refractory + en gating:
  - refrac=0: FIRE returns directly to INTEG after 1 cycle.
  - en=0 for 5 cycles with inputs active: membrane and prescaler unchanged.
- Async reset during REFRAC (counter=2): all outputs clear immediately; after release the neuron integrates from 0 in INTEG.

Source files
------------

// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared types and sizing helpers for the LIF neuron
// Contents:
//   lif_state_e  : neuron FSM state; its encoding is the state_dbg value
//   SPIKE_CNT_W  : width of the saturating fire counter
//   syn_width()  : bits needed to hold the masked weight sum without overflow
package lif_pkg;

  typedef enum logic [1:0] {
    INTEG  = 2'd0,
    FIRE   = 2'd1,
    REFRAC = 2'd2
  } lif_state_e;

  localparam int SPIKE_CNT_W = 16;

  // The sum of NUM_IN unsigned WIDTH-bit weights needs WIDTH+clog2(NUM_IN) bits.
  // The extra bit keeps the NUM_IN=1 case and any future rounding of clog2 safe.
  function automatic int syn_width(input int width, input int num_in);
    return width + $clog2(num_in) + 1;
  endfunction

endpackage

// File: rtl/lif_syn_sum.sv
// rtl/lif_syn_sum.sv - combinational masked sum of synaptic weights
// Ports:
//   spike_in [NUM_IN]        : input i contributes its weight when high
//   weight   [NUM_IN*WIDTH]  : unsigned weight i at [i*WIDTH +: WIDTH]
//   syn      [syn_width]     : sum of the weights of the active inputs
module lif_syn_sum
  import lif_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  localparam int SW    = syn_width(WIDTH, NUM_IN)
) (
  input  logic [NUM_IN-1:0]       spike_in,
  input  logic [NUM_IN*WIDTH-1:0] weight,
  output logic [SW-1:0]           syn
);

  always_comb begin
    syn = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (spike_in[i]) begin
        syn = syn + SW'(weight[i*WIDTH +: WIDTH]);
      end
    end
  end

endmodule

// File: rtl/lif_neuron_param.sv
// rtl/lif_neuron_param.sv - parametrised multi-input leaky-integrate-and-fire neuron
// Ports:
//   clk, rst_n     : rising-edge clock, asynchronous active-low reset
//   en             : enables integration and the leak prescaler (INTEG only)
//   spike_in       : synaptic inputs, one bit per input
//   weight         : packed unsigned weights, input i at [i*WIDTH +: WIDTH]
//   threshold      : fire when the clamped next membrane value >= threshold
//   leak           : amount subtracted on each leak tick
//   v_reset        : membrane value loaded when the neuron fires
//   refrac_cycles  : refractory length in cycles, sampled when firing (0 = none)
//   membrane       : membrane potential register
//   spike          : one-cycle fire pulse, high while in FIRE
//   state_dbg      : encoded FSM state (INTEG=0, FIRE=1, REFRAC=2)
//   spike_count    : saturating count of fires
module lif_neuron_param
  import lif_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NUM_IN   = 4,
  parameter int LEAK_DIV = 4,
  parameter int REFRAC_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [NUM_IN-1:0]       spike_in,
  input  logic [NUM_IN*WIDTH-1:0] weight,
  input  logic [WIDTH-1:0]        threshold,
  input  logic [WIDTH-1:0]        leak,
  input  logic [WIDTH-1:0]        v_reset,
  input  logic [REFRAC_W-1:0]     refrac_cycles,
  output logic [WIDTH-1:0]        membrane,
  output logic                    spike,
  output logic [1:0]              state_dbg,
  output logic [SPIKE_CNT_W-1:0]  spike_count
);

  localparam int SW = syn_width(WIDTH, NUM_IN);
  // One bit wider than the sum so that membrane + syn - leak is exact and signed.
  localparam int NW = SW + 1;
  // A LEAK_DIV of 1 still needs a one-bit prescaler; it simply ticks every cycle.
  localparam int PW = (LEAK_DIV > 1) ? $clog2(LEAK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(LEAK_DIV - 1);

  lif_state_e             state_q, state_d;
  logic [WIDTH-1:0]       mem_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic [REFRAC_W-1:0]    rcnt_q, rcnt_d;
  logic [SPIKE_CNT_W-1:0] cnt_d;
  logic [SW-1:0]          syn;
  logic                   tick;
  logic signed [NW-1:0]   nxt;
  logic [WIDTH-1:0]       clamped;

  lif_syn_sum #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_syn_sum (
    .spike_in (spike_in),
    .weight   (weight),
    .syn      (syn)
  );

  assign tick = (presc_q == PRESC_LAST);
  assign nxt  = $signed(NW'(membrane) + NW'(syn) - (tick ? NW'(leak) : NW'(0)));

  // Clamp into [0, 2^WIDTH-1] before the threshold compare.
  always_comb begin
    if (nxt[NW-1]) begin
      clamped = '0;
    end else if (|nxt[NW-2:WIDTH]) begin
      clamped = '1;
    end else begin
      clamped = nxt[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    mem_d   = membrane;
    presc_d = presc_q;
    rcnt_d  = rcnt_q;
    cnt_d   = spike_count;
    case (state_q)
      INTEG: begin
        if (en) begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (clamped >= threshold) begin
            mem_d   = v_reset;
            state_d = FIRE;
            // Refractory length is captured here so later changes cannot stretch it.
            rcnt_d  = refrac_cycles;
            if (spike_count != '1) begin
              cnt_d = spike_count + 1'b1;
            end
          end else begin
            mem_d = clamped;
          end
        end
      end
      FIRE: begin
        state_d = (rcnt_q == '0) ? INTEG : REFRAC;
      end
      REFRAC: begin
        rcnt_d = rcnt_q - 1'b1;
        if (rcnt_q == REFRAC_W'(1)) begin
          state_d = INTEG;
        end
      end
      default: begin
        state_d = INTEG;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INTEG;
      membrane    <= '0;
      presc_q     <= '0;
      rcnt_q      <= '0;
      spike_count <= '0;
    end else begin
      state_q     <= state_d;
      membrane    <= mem_d;
      presc_q     <= presc_d;
      rcnt_q      <= rcnt_d;
      spike_count <= cnt_d;
    end
  end

  assign spike     = (state_q == FIRE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_lif_neuron_param.sv
// tb/tb_lif_neuron_param.sv - self-checking bench for lif_neuron_param
module tb_lif_neuron_param;

  localparam int WIDTH    = 8;
  localparam int NUM_IN   = 4;
  localparam int LEAK_DIV = 4;
  localparam int REFRAC_W = 4;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   en = 1'b0;
  logic [NUM_IN-1:0]       spike_in = '0;
  logic [NUM_IN*WIDTH-1:0] weight = '0;
  logic [WIDTH-1:0]        threshold = '0;
  logic [WIDTH-1:0]        leak = '0;
  logic [WIDTH-1:0]        v_reset = '0;
  logic [REFRAC_W-1:0]     refrac_cycles = '0;
  logic [WIDTH-1:0]        membrane;
  logic                    spike;
  logic [1:0]              state_dbg;
  logic [15:0]             spike_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lif_neuron_param #(
    .WIDTH    (WIDTH),
    .NUM_IN   (NUM_IN),
    .LEAK_DIV (LEAK_DIV),
    .REFRAC_W (REFRAC_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .spike_in      (spike_in),
    .weight        (weight),
    .threshold     (threshold),
    .leak          (leak),
    .v_reset       (v_reset),
    .refrac_cycles (refrac_cycles),
    .membrane      (membrane),
    .spike         (spike),
    .state_dbg     (state_dbg),
    .spike_count   (spike_count)
  );

  // Reference model: phase 0=integrating, 1=firing, 2=refractory.
  int m_mem, m_phase, m_left, m_steps, m_cnt;

  task automatic model_reset();
    m_mem = 0; m_phase = 0; m_left = 0; m_steps = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    int syn, v;
    bit tk;
    if (m_phase == 0) begin
      if (en) begin
        syn = 0;
        for (int i = 0; i < NUM_IN; i++)
          if (spike_in[i]) syn += int'(weight[i*WIDTH +: WIDTH]);
        tk = (m_steps % LEAK_DIV) == LEAK_DIV - 1;
        m_steps++;
        v = m_mem + syn - (tk ? int'(leak) : 0);
        if (v < 0) v = 0;
        if (v > (1 << WIDTH) - 1) v = (1 << WIDTH) - 1;
        if (v >= int'(threshold)) begin
          m_mem = int'(v_reset);
          m_phase = 1;
          m_left = int'(refrac_cycles);
          if (m_cnt < 65535) m_cnt++;
        end else begin
          m_mem = v;
        end
      end
    end else if (m_phase == 1) begin
      m_phase = (m_left > 0) ? 2 : 0;
    end else begin
      m_left--;
      if (m_left == 0) m_phase = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("model_membrane", 32'(membrane), m_mem);
    check("model_spike", 32'(spike), (m_phase == 1) ? 1 : 0);
    check("model_state", 32'(state_dbg), m_phase);
    check("model_count", 32'(spike_count), m_cnt);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  // Asserts reset between edges, checks the outputs clear before any edge, releases on negedge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_membrane", 32'(membrane), 0);
    check("rst_spike", 32'(spike), 0);
    check("rst_state", 32'(state_dbg), 0);
    check("rst_count", 32'(spike_count), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic common_setup();
    weight        = {8'd1, 8'd5, 8'd10, 8'd20};
    threshold     = 8'd50;
    leak          = 8'd0;
    v_reset       = 8'd0;
    refrac_cycles = 4'd3;
    en            = 1'b1;
    spike_in      = '0;
  endtask

  typedef struct {
    logic [3:0] sin;
    int         mem;
    logic       spk;
    logic [1:0] st;
    int         cnt;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // Integrate / fire / refractory / integrate / fire, input 0 (weight 20) held.
    tbl[0]  = '{4'b0001, 20, 1'b0, 2'd0, 0};
    tbl[1]  = '{4'b0001, 40, 1'b0, 2'd0, 0};
    tbl[2]  = '{4'b0001,  0, 1'b1, 2'd1, 1};
    tbl[3]  = '{4'b0001,  0, 1'b0, 2'd2, 1};
    tbl[4]  = '{4'b0001,  0, 1'b0, 2'd2, 1};
    tbl[5]  = '{4'b0001,  0, 1'b0, 2'd2, 1};
    tbl[6]  = '{4'b0001,  0, 1'b0, 2'd0, 1};
    tbl[7]  = '{4'b0001, 20, 1'b0, 2'd0, 1};
    tbl[8]  = '{4'b0001, 40, 1'b0, 2'd0, 1};
    tbl[9]  = '{4'b0001,  0, 1'b1, 2'd1, 2};
    tbl[10] = '{4'b0001,  0, 1'b0, 2'd2, 2};

    common_setup();
    model_reset();
    do_reset();

    for (int i = 0; i < 11; i++) begin
      spike_in = tbl[i].sin;
      cycle();
      check("tbl_membrane", 32'(membrane), tbl[i].mem);
      check("tbl_spike", 32'(spike), 32'(tbl[i].spk));
      check("tbl_state", 32'(state_dbg), 32'(tbl[i].st));
      check("tbl_count", 32'(spike_count), tbl[i].cnt);
    end

    // Leak floor: preload 3, then leak 2 per tick every LEAK_DIV cycles, clamped at 0.
    common_setup();
    do_reset();
    spike_in = 4'b1000;
    repeat (3) cycle();
    check("leak_preload", 32'(membrane), 3);
    spike_in = '0;
    leak = 8'd2;
    cycle();
    check("leak_first_tick", 32'(membrane), 1);
    repeat (3) cycle();
    check("leak_between_ticks", 32'(membrane), 1);
    cycle();
    check("leak_floor", 32'(membrane), 0);
    repeat (4) cycle();
    check("leak_floor_hold", 32'(membrane), 0);

    // Saturation: 36 per cycle up to 252, then clamp to 255 and fire.
    common_setup();
    do_reset();
    threshold = 8'd255;
    spike_in = 4'b1111;
    repeat (7) cycle();
    check("sat_252", 32'(membrane), 252);
    check("sat_no_spike", 32'(spike), 0);
    cycle();
    check("sat_fire", 32'(spike), 1);
    check("sat_count", 32'(spike_count), 1);

    // Zero refractory, then en gating must freeze membrane and prescaler.
    common_setup();
    do_reset();
    refrac_cycles = 4'd0;
    spike_in = 4'b0001;
    repeat (3) cycle();
    check("zref_fire", 32'(spike), 1);
    cycle();
    check("zref_back_integ", 32'(state_dbg), 0);
    en = 1'b0;
    spike_in = 4'b1111;
    repeat (5) cycle();
    check("en_gate_mem", 32'(membrane), 0);
    en = 1'b1;
    spike_in = 4'b0001;
    leak = 8'd5;
    cycle();
    check("en_gate_presc", 32'(membrane), 15);
    leak = 8'd0;

    // Async reset while refractory counter is 2.
    common_setup();
    do_reset();
    spike_in = 4'b0001;
    repeat (5) cycle();
    check("refrac_before_rst", 32'(state_dbg), 2);
    do_reset();
    cycle();
    check("post_rst_mem", 32'(membrane), 20);
    check("post_rst_state", 32'(state_dbg), 0);

    // threshold = 0 fires on every enabled INTEG evaluation.
    common_setup();
    do_reset();
    threshold = 8'd0;
    refrac_cycles = 4'd0;
    repeat (4) cycle();
    check("thr0_count", 32'(spike_count), 2);

    // Randomised run against the model.
    common_setup();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n % 60 == 0) begin
        weight        = NUM_IN*WIDTH'($urandom());
        threshold     = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
        leak          = 8'($urandom_range(0, 30));
        v_reset       = 8'($urandom_range(0, 255));
        refrac_cycles = 4'($urandom_range(0, 15));
      end
      spike_in = 4'($urandom());
      en = ($urandom_range(0, 9) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
